// File: rtl/sass_gpio_pkg.sv
// Shared constants and helpers for the GPIO front end.
// Holds the default bank geometry and the function that builds the
// active-state output-enable vector (0 on the output slice, 1 elsewhere).
package sass_gpio_pkg;

  localparam int NUM_GPIO_DEF    = 34;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_DEF    = 4;
  // Widest bank the mask helper can describe.
  localparam int MAX_GPIO        = 64;

  function automatic logic [MAX_GPIO-1:0] oeb_mask(input int num_gpio,
                                                   input int out_lsb,
                                                   input int out_w);
    logic [MAX_GPIO-1:0] m;
    m = '1;
    for (int i = 0; i < MAX_GPIO; i++) begin
      if (i < num_gpio && i >= out_lsb && i < out_lsb + out_w) begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sass_debounce.sv
// One-bit debouncer / edge detector fed by an already synchronised input.
// Ports: i_clk, i_nrst (sync active-low), i_clr (sync clear, held while the
// bank is deselected), i_sync (synchronised level), o_level, o_rise (one-cycle 0->1 pulse).
module sass_debounce #(
  parameter int DEBOUNCE = 4,
  parameter bit BYPASS   = 1'b0
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_clr,
  input  logic i_sync,
  output logic o_level,
  output logic o_rise
);

  logic r_stable;
  logic r_stable_prev;

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_clr) begin
      r_stable_prev <= 1'b0;
    end else begin
      r_stable_prev <= r_stable;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      always_ff @(posedge i_clk) begin
        if (!i_nrst || i_clr) begin
          r_stable <= 1'b0;
        end else begin
          r_stable <= i_sync;
        end
      end
    end else begin : g_db
      localparam int CW = $clog2(DEBOUNCE + 1);
      logic [CW-1:0] r_cnt;

      // The clear has priority, so a deselect landing on the same edge as a
      // completed count leaves the level at 0 and no pulse is produced.
      always_ff @(posedge i_clk) begin
        if (!i_nrst || i_clr) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (i_sync == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
          // This sample would be the DEBOUNCE-th consecutive differing one.
          r_stable <= i_sync;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign o_level = r_stable;
  assign o_rise  = r_stable & ~r_stable_prev;

endmodule

// File: rtl/sass_gpio_frontend.sv
// Pin front end between a GPIO bank and a synthesiser core: input sync,
// debounce and rise pulses, registered outputs, output enables, chip-select parking.
// Ports: i_clk, i_nrst, i_ncs, i_gpio_in, i_core_out; o_gpio_out, o_gpio_oeb, o_core_in, o_core_in_rise, o_active.
module sass_gpio_frontend
  import sass_gpio_pkg::*;
#(
  parameter int              NUM_GPIO    = NUM_GPIO_DEF,
  parameter int              IN_LSB      = 0,
  parameter int              IN_W        = 18,
  parameter int              OUT_LSB     = 18,
  parameter int              OUT_W       = 12,
  parameter int              SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int              DEBOUNCE    = DEBOUNCE_DEF,
  parameter logic [IN_W-1:0] DB_MASK     = '1
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic                i_ncs,
  input  logic [NUM_GPIO-1:0] i_gpio_in,
  output logic [NUM_GPIO-1:0] o_gpio_out,
  output logic [NUM_GPIO-1:0] o_gpio_oeb,
  output logic [IN_W-1:0]     o_core_in,
  output logic [IN_W-1:0]     o_core_in_rise,
  input  logic [OUT_W-1:0]    i_core_out,
  output logic                o_active
);

  generate
    if (NUM_GPIO > MAX_GPIO) begin : g_chk_num
      $fatal(1, "NUM_GPIO exceeds MAX_GPIO");
    end
    if (IN_LSB < 0 || IN_W < 1 || IN_LSB + IN_W > NUM_GPIO) begin : g_chk_in
      $fatal(1, "input slice outside the bank");
    end
    if (OUT_LSB < 0 || OUT_W < 1 || OUT_LSB + OUT_W > NUM_GPIO) begin : g_chk_out
      $fatal(1, "output slice outside the bank");
    end
    if (!(IN_LSB + IN_W <= OUT_LSB || OUT_LSB + OUT_W <= IN_LSB)) begin : g_chk_ovl
      $fatal(1, "input and output slices overlap");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
      $fatal(1, "SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE < 1) begin : g_chk_db
      $fatal(1, "DEBOUNCE must be at least 1");
    end
  endgenerate

  localparam logic [MAX_GPIO-1:0] OEB_ACT = oeb_mask(NUM_GPIO, OUT_LSB, OUT_W);

  logic [SYNC_STAGES-1:0][IN_W-1:0] r_in_sync;
  logic [SYNC_STAGES-1:0]           r_ncs_sync;
  logic [OUT_W-1:0]                 r_out;
  logic [IN_W-1:0]                  w_sync;
  logic                             w_active;
  // Pins outside the input slice are read by nothing; folded here so the
  // whole pad vector is consumed.
  logic                             w_unused_pins;

  // The ncs chain parks at 1 so the bank comes out of reset deselected.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_in_sync  <= '0;
      r_ncs_sync <= '1;
    end else begin
      r_in_sync  <= {r_in_sync[SYNC_STAGES-2:0], i_gpio_in[IN_LSB +: IN_W]};
      r_ncs_sync <= {r_ncs_sync[SYNC_STAGES-2:0], i_ncs};
    end
  end

  assign w_sync        = r_in_sync[SYNC_STAGES-1];
  assign w_active      = ~r_ncs_sync[SYNC_STAGES-1];
  assign w_unused_pins = ^i_gpio_in;

  always_ff @(posedge i_clk) begin
    if (!i_nrst || !w_active) begin
      r_out <= '0;
    end else begin
      r_out <= i_core_out;
    end
  end

  always_comb begin
    o_gpio_out = '0;
    o_gpio_out[OUT_LSB +: OUT_W] = r_out;
  end

  // Enables follow the synchronised select directly, no extra register.
  assign o_gpio_oeb = w_active ? OEB_ACT[NUM_GPIO-1:0] : '1;
  assign o_active   = w_active;

  generate
    for (genvar i = 0; i < IN_W; i++) begin : g_in
      sass_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .BYPASS   (!DB_MASK[i])
      ) u_db (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_clr   (~w_active),
        .i_sync  (w_sync[i]),
        .o_level (o_core_in[i]),
        .o_rise  (o_core_in_rise[i])
      );
    end
  endgenerate

endmodule
